alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU, with a
// single-entry response register that sustains one operation per cycle.
module alu_arbiter #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_sel,
  input  logic [DWIDTH-1:0] req0_rs1,
  input  logic [DWIDTH-1:0] req0_rs2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_sel,
  input  logic [DWIDTH-1:0] req1_rs1,
  input  logic [DWIDTH-1:0] req1_rs2,
  output logic [3:0]        alu_sel,
  output logic [DWIDTH-1:0] alu_rs1,
  output logic [DWIDTH-1:0] alu_rs2,
  input  logic [DWIDTH-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic can_accept;
  logic any_valid;
  logic win_idx;
  logic grant;
  logic sel_legal;

  // The round-robin pointer only matters when both requesters contend.
  always_comb begin
    can_accept = (state_q == StEmpty) | (rsp_valid & rsp_ready);
    any_valid  = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_idx = ~last_grant_q;
    end else begin
      win_idx = req1_valid;
    end
    grant      = any_valid & can_accept & ~rst;
    req0_ready = grant & ~win_idx;
    req1_ready = grant & win_idx;
  end

  always_comb begin
    alu_sel = '0;
    alu_rs1 = '0;
    alu_rs2 = '0;
    if (any_valid) begin
      if (win_idx) begin
        alu_sel = req1_sel;
        alu_rs1 = req1_rs1;
        alu_rs2 = req1_rs2;
      end else begin
        alu_sel = req0_sel;
        alu_rs1 = req0_rs1;
        alu_rs2 = req0_rs2;
      end
    end
  end

  always_comb begin
    case (alu_sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: sel_legal = 1'b1;
      default:                                     sel_legal = 1'b0;
    endcase
  end

  // A grant always reloads the register, whether or not it is draining.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    if (grant) begin
      state_d      = StFull;
      last_grant_d = win_idx;
      rsp_id_d     = win_idx;
      rsp_data_d   = alu_out;
      rsp_err_d    = ~sel_legal;
    end else if (rsp_valid && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU feeds alu_out, grants push
// expected responses, and drained responses are popped and compared.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_sel, req1_sel;
  logic [W-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_rs1, alu_rs2, alu_out;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic tb_last  = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.DWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_sel  (req0_sel),
    .req0_rs1  (req0_rs1),
    .req0_rs2  (req0_rs2),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_sel  (req1_sel),
    .req1_rs1  (req1_rs1),
    .req1_rs2  (req1_rs2),
    .alu_sel   (alu_sel),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  function automatic logic [W-1:0] alu_f(input logic [3:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (s)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0100: return {31'b0, $signed(a) < $signed(b)};
      4'b0110: return {31'b0, a < b};
      4'b1000: return a ^ b;
      4'b1010: return a >> b[4:0];
      4'b1011: return $unsigned($signed(a) >>> b[4:0]);
      4'b1100: return a | b;
      4'b1110: return a & b;
      default: return '0;
    endcase
  endfunction

  function automatic logic err_f(input logic [3:0] s);
    case (s)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: return 1'b0;
      default:                                     return 1'b1;
    endcase
  endfunction

  assign alu_out = alu_f(alu_sel, alu_rs1, alu_rs2);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
  endtask

  // Scoreboard monitor: pop before push, since a response visible now belongs to
  // an earlier grant.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      tb_last = 1'b1;
      check_eq("rst_ready", {62'b0, req1_ready, req0_ready}, 64'd0);
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("rsp_id", {63'b0, rsp_id}, {63'b0, e.id});
          check_eq("rsp_data", {32'b0, rsp_data}, {32'b0, e.data});
          check_eq("rsp_err", {63'b0, rsp_err}, {63'b0, e.err});
        end
      end
      if (req0_ready && req1_ready) check_eq("one_grant", 64'd2, 64'd1);
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid))
        check_eq("grant_no_valid", 64'd1, 64'd0);
      if (rsp_valid && !rsp_ready && (req0_valid || req1_valid))
        check_eq("stall_ready", {62'b0, req1_ready, req0_ready}, 64'd0);
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        check_eq("rr_winner", {63'b0, req1_ready}, {63'b0, ~tb_last});
      if (req0_valid && req0_ready) begin
        q.push_back('{id: 1'b0, data: alu_f(req0_sel, req0_rs1, req0_rs2), err: err_f(req0_sel)});
        tb_last = 1'b0;
      end else if (req1_valid && req1_ready) begin
        q.push_back('{id: 1'b1, data: alu_f(req1_sel, req1_rs1, req1_rs2), err: err_f(req1_sel)});
        tb_last = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    req0_valid = v; req0_sel = s; req0_rs1 = a; req0_rs2 = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    req1_valid = v; req1_sel = s; req1_rs1 = a; req1_rs2 = b;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] rr_exp [4];
  logic       t0, t1;

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    rst = 1'b1; rsp_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd1, 32'd1);
    set_req1(1'b1, 4'b0000, 32'd2, 32'd2);
    tick();
    tick();
    @(negedge clk);
    check_eq("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check_eq("reset_rsp_data", {32'b0, rsp_data}, 64'd0);
    check_eq("reset_rsp_id_err", {62'b0, rsp_id, rsp_err}, 64'd0);

    // Single requester, 5 + 3.
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    set_req0(1'b1, 4'b0000, 32'd5, 32'd3);
    set_req1(1'b0, 4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    check_eq("t1_req0_ready", {63'b0, req0_ready}, 64'd1);
    check_eq("t1_alu_rs1", {32'b0, alu_rs1}, 64'd5);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    check_eq("t1_rsp", {31'b0, rsp_id, rsp_data, rsp_err}, {31'b0, 1'b0, 32'd8, 1'b0});
    check_eq("t1_idle_alu", {28'b0, alu_sel, alu_rs1}, 64'd0);
    tick();

    // Contention with back-to-back draining.
    pulse_rst();
    set_req0(1'b1, 4'b0001, 32'd10, 32'd4);
    set_req1(1'b1, 4'b1011, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_grant%0d", i), {62'b0, req1_ready, req0_ready}, {62'b0, rr_exp[i]});
      if (i == 2) begin
        check_eq("t2_rsp1", {31'b0, rsp_id, rsp_data}, {31'b0, 1'b1, 32'hF800_0000});
      end
      tick();
    end
    set_req0(1'b0, 4'b0000, 32'd0, 32'd0);
    set_req1(1'b0, 4'b0000, 32'd0, 32'd0);
    tick();
    tick();

    // Back-pressure hold.
    rsp_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd7, 32'd1);
    tick();
    req0_valid = 1'b0;
    set_req1(1'b1, 4'b1000, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_hold_ready", {63'b0, req1_ready}, 64'd0);
      check_eq("t3_hold_rsp", {30'b0, rsp_valid, rsp_id, rsp_data, rsp_err},
               {30'b0, 1'b1, 1'b0, 32'd8, 1'b0});
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_req1_ready", {63'b0, req1_ready}, 64'd1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_rsp", {31'b0, rsp_id, rsp_data}, {31'b0, 1'b1, 32'hFF});
    tick();

    // Illegal op code.
    set_req0(1'b1, 4'b0011, 32'd1, 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_err", {31'b0, rsp_err, rsp_data}, {31'b0, 1'b1, 32'd0});
    tick();

    // Reset discards a held result and restores req0 priority.
    rsp_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd2, 32'd2);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_ready", {62'b0, req1_ready, req0_ready}, 64'd0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    set_req0(1'b1, 4'b0001, 32'd9, 32'd3);
    set_req1(1'b1, 4'b0000, 32'd1, 32'd1);
    @(negedge clk);
    check_eq("t5_rsp_cleared", {31'b0, rsp_valid, rsp_data}, 64'd0);
    check_eq("t5_first_grant", {62'b0, req1_ready, req0_ready}, 64'd1);
    tick();

    // Random traffic; a requester holds its operation until it is granted.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      t0 = req0_valid & req0_ready;
      t1 = req1_valid & req1_ready;
      tick();
      if (t0 || !req0_valid)
        set_req0(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      if (t1 || !req1_valid)
        set_req1(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    tick();
    set_req0(1'b0, 4'b0000, 32'd0, 32'd0);
    set_req1(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || rsp_valid); i++) tick();
    check_eq("drain_queue", 64'(q.size()), 64'd0);
    check_eq("drain_valid", {63'b0, rsp_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
